// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: state encodings and default parameters shared by the reset sequencer
package reset_seq_pkg;
  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    REL_ADC   = 3'd2,
    REL_DAC   = 3'd3,
    RUN       = 3'd4
  } state_t;
  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_STAGE_GAP_CYCLES = 16;
  localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: 2-flop synchronizer with a selectable synchronous reset value
module bit_synchronizer #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk) begin
    if (rst) {q, meta} <= {2{RESET_VAL}};
    else {q, meta} <= {meta, d};
  end
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: waits for stable PLL lock, then releases ADC, DAC and core resets in order
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int STAGE_GAP_CYCLES = DEF_STAGE_GAP_CYCLES,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_pll_unlocked,
  input  logic       i_clear_fault,
  output logic       o_adc_reset,
  output logic       o_dac_reset,
  output logic       o_core_reset,
  output logic       o_ready,
  output logic       o_lock_lost,
  output logic [2:0] o_state
);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(STAGE_GAP_CYCLES - 1);
  logic pll_unlocked_sync, pll_ok, fault;
  state_t state, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  // Synchronizer resets to "unlocked" so nothing is released until lock is seen afresh
  bit_synchronizer #(.RESET_VAL(1'b1)) u_pll_sync (
    .clk(i_clock),
    .rst(i_reset),
    .d(i_pll_unlocked),
    .q(pll_unlocked_sync)
  );
  assign pll_ok = ~pll_unlocked_sync;
  always_comb begin
    nxt = state;
    cnt_nxt = '0;
    fault = 1'b0;
    if (!pll_ok) begin
      nxt = WAIT_LOCK;
      fault = state inside {REL_ADC, REL_DAC, RUN};
    end else begin
      case (state)
        WAIT_LOCK: nxt = STABLE;
        STABLE:    if (cnt == LOCK_LAST) nxt = REL_ADC; else cnt_nxt = cnt + 1'b1;
        REL_ADC:   if (cnt == GAP_LAST) nxt = REL_DAC; else cnt_nxt = cnt + 1'b1;
        REL_DAC:   if (cnt == GAP_LAST) nxt = RUN; else cnt_nxt = cnt + 1'b1;
        RUN:       nxt = RUN;
        default:   nxt = WAIT_LOCK;
      endcase
    end
  end
  // Outputs are decoded from the next state so they switch on the same edge as the state
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= WAIT_LOCK;
      cnt <= '0;
      o_adc_reset <= 1'b1;
      o_dac_reset <= 1'b1;
      o_core_reset <= 1'b1;
      o_ready <= 1'b0;
      o_lock_lost <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      o_adc_reset <= !(nxt inside {REL_ADC, REL_DAC, RUN});
      o_dac_reset <= !(nxt inside {REL_DAC, RUN});
      o_core_reset <= nxt != RUN;
      o_ready <= nxt == RUN;
      o_lock_lost <= fault | (o_lock_lost & ~i_clear_fault);
    end
  end
  assign o_state = state;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed and randomized checks against a lock-run-length model
module tb_reset_sequencer;
  localparam int N = 8;
  localparam int G = 4;
  logic clk = 1'b0;
  logic rst, unlocked, clear;
  logic adc, dac, core, ready, lost;
  logic [2:0] state;
  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  logic m_s1, m_s2, m_lost;
  int m_run;
  always #5 clk = ~clk;
  reset_sequencer #(.LOCK_STABLE_CYCLES(N), .STAGE_GAP_CYCLES(G), .CNT_W(4)) dut (
    .i_clock(clk),
    .i_reset(rst),
    .i_pll_unlocked(unlocked),
    .i_clear_fault(clear),
    .o_adc_reset(adc),
    .o_dac_reset(dac),
    .o_core_reset(core),
    .o_ready(ready),
    .o_lock_lost(lost),
    .o_state(state)
  );
  // m_run: consecutive locked cycles up to the previous cycle; every output follows from it
  always @(posedge clk) begin
    if (rst) begin
      m_s1 <= 1'b1;
      m_s2 <= 1'b1;
      m_run <= 0;
      m_lost <= 1'b0;
    end else begin
      m_s1 <= unlocked;
      m_s2 <= m_s1;
      m_run <= m_s2 ? 0 : (m_run < 100000 ? m_run + 1 : m_run);
      m_lost <= (m_s2 && m_run > N) || (m_lost && !clear);
    end
  end
  function automatic logic [7:0] model_out(input int r, input logic l);
    logic [2:0] st;
    st = r == 0 ? 3'd0 : r <= N ? 3'd1 : r <= N + G ? 3'd2 : r <= N + 2 * G ? 3'd3 : 3'd4;
    return {r <= N, r <= N + G, r <= N + 2 * G, r > N + 2 * G, l, st};
  endfunction
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({adc, dac, core, ready, lost, state} !== model_out(m_run, m_lost)) begin
        failures++;
        if (failures <= 20)
          $display("FAIL model_cmp t=%0t actual=%b expected=%b", $time,
                   {adc, dac, core, ready, lost, state}, model_out(m_run, m_lost));
      end
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask
  initial begin
    int left;
    rst = 1'b1;
    unlocked = 1'b1;
    clear = 1'b0;
    step(3);
    chk("reset_outs", {adc, dac, core, ready, lost, state}, 8'b11100000);
    chk_en = 1'b1;
    rst = 1'b0;
    unlocked = 1'b0;
    step(10);
    chk("bringup_adc_hold", {7'd0, adc}, 8'd1);
    step(1);
    chk("bringup_adc_fall", {3'd0, adc, dac, state}, {3'd0, 1'b0, 1'b1, 3'd2});
    step(3);
    chk("bringup_dac_hold", {7'd0, dac}, 8'd1);
    step(1);
    chk("bringup_dac_fall", {4'd0, dac, state}, {4'd0, 1'b0, 3'd3});
    step(3);
    chk("bringup_core_hold", {6'd0, core, ready}, 8'b10);
    step(1);
    chk("bringup_run", {adc, dac, core, ready, lost, state}, 8'b00010100);
    unlocked = 1'b1;
    step(2);
    chk("loss_not_yet", {7'd0, ready}, 8'd1);
    step(1);
    chk("loss_reaction", {adc, dac, core, ready, lost, state}, 8'b11101000);
    unlocked = 1'b0;
    step(19);
    chk("relock_run", {3'd0, ready, lost, state}, {3'd0, 1'b1, 1'b1, 3'd4});
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("clear_fault", {7'd0, lost}, 8'd0);
    unlocked = 1'b1;
    step(2);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("clear_vs_loss", {7'd0, lost}, 8'd1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    unlocked = 1'b0;
    step(6);
    unlocked = 1'b1;
    step(1);
    unlocked = 1'b0;
    step(10);
    chk("glitch_adc_hold", {3'd0, adc, lost, state}, {3'd0, 1'b1, 1'b0, 3'd1});
    step(1);
    chk("glitch_adc_fall", {3'd0, adc, lost, state}, {3'd0, 1'b0, 1'b0, 3'd2});
    step(4);
    chk("mid_rel_dac", {5'd0, state}, 8'd3);
    rst = 1'b1;
    step(1);
    chk("mid_reset", {adc, dac, core, ready, lost, state}, 8'b11100000);
    rst = 1'b0;
    step(10);
    chk("restart_adc_hold", {7'd0, adc}, 8'd1);
    step(1);
    chk("restart_adc_fall", {4'd0, adc, state}, {4'd0, 1'b0, 3'd2});
    left = 0;
    repeat (3000) begin
      if (left == 0) begin
        unlocked = $urandom_range(0, 3) == 0;
        left = $urandom_range(1, 40);
      end
      left--;
      clear = $urandom_range(0, 19) == 0;
      rst = $urandom_range(0, 499) == 0;
      step(1);
    end
    clear = 1'b0;
    unlocked = 1'b1;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(5000);
    chk("never_lock", {adc, dac, core, ready, lost, state}, 8'b11100000);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Consumes the clock unit's PLL status (`o_valid`, high while the PLL is unlocked) in the 100 MHz `sys_clock` domain. Holds the ADC, DAC and core resets asserted until lock has been stable for a programmable time, then releases them in a fixed order with programmable gaps. Any loss of lock re-asserts all resets and records a sticky fault.

## Interface
- `LOCK_STABLE_CYCLES`, default 1024: consecutive locked cycles required before the first release; must be ≥ 1.
- `STAGE_GAP_CYCLES`, default 16: cycles between successive reset releases; must be ≥ 1.
- `CNT_W`, default 16: counter width; must be ≥ clog2(max(LOCK_STABLE_CYCLES, STAGE_GAP_CYCLES)).
- `i_clock` in 1: `sys_clock` (100 MHz) from the clock unit.
- `i_reset` in 1: one clock; reset is synchronous and active-high.
- `i_pll_unlocked` in 1: clock unit `o_valid`; 1 = PLL not locked; asynchronous to `i_clock`.
- `i_clear_fault` in 1: single-cycle pulse that clears `o_lock_lost`.
- `o_adc_reset` out 1: active-high reset for the ADC capture path.
- `o_dac_reset` out 1: active-high reset for the DAC path.
- `o_core_reset` out 1: active-high reset for the processing core.
- `o_ready` out 1: 1 when all resets are released (state RUN).
- `o_lock_lost` out 1: sticky; set when lock drops after any reset has been released.
- `o_state` out 3: current state encoding, for debug/ILA.

## Operation
- `i_pll_unlocked` passes through a 2-flop synchronizer; `pll_ok` = NOT(synchronized value). On `i_reset` the synchronizer flops load 1, so `pll_ok` = 0.
- States:
  - WAIT_LOCK: all resets asserted. If `pll_ok` → STABLE, counter = 0.
  - STABLE: while `pll_ok`, counter increments. If counter == LOCK_STABLE_CYCLES−1 → REL_ADC, counter = 0.
  - REL_ADC: `o_adc_reset` = 0. If counter == STAGE_GAP_CYCLES−1 → REL_DAC, counter = 0; else counter increments.
  - REL_DAC: `o_dac_reset` = 0. If counter == STAGE_GAP_CYCLES−1 → RUN.
  - RUN: `o_core_reset` = 0, `o_ready` = 1. RUN is terminal while locked.
- Unlock handling:
  - `pll_ok` = 0 in any state other than WAIT_LOCK → WAIT_LOCK; counter = 0.
  - `pll_ok` = 0 in STABLE is not a fault. `o_lock_lost` is not set.
  - `pll_ok` = 0 in REL_ADC, REL_DAC or RUN sets `o_lock_lost`.
- `o_lock_lost` is cleared by `i_clear_fault` or `i_reset`. If set and clear occur in the same cycle, set wins.
- Counter width is CNT_W, unsigned; compare by equality only; the counter never wraps.
- Resets are released to other clock domains (`adc_clock`, `dac_clock`). Consumers re-synchronize deassertion locally; this block guarantees only that the outputs are glitch-free.

## Timing
- All outputs are registered. They change on the same edge as the state register, decoded from the next state; there are no combinational outputs.
- Reset values:
  - `o_adc_reset`, `o_dac_reset`, `o_core_reset` = 1.
  - `o_ready` = 0, `o_lock_lost` = 0.
  - `o_state` = WAIT_LOCK (0). Counter = 0.
- `i_reset` mid-sequence: on the next edge, all outputs return to their reset values, regardless of state or `pll_ok`.
- Latency from `i_pll_unlocked` falling:
  - `pll_ok` rises 2 edges later; call the first cycle with `pll_ok` = 1 cycle t.
  - STABLE occupies cycles t+1 … t+N, where N = LOCK_STABLE_CYCLES and G = STAGE_GAP_CYCLES.
  - `o_adc_reset` = 0 from cycle t+N+1.
  - `o_dac_reset` = 0 from t+N+G+1.
  - `o_core_reset` = 0 and `o_ready` = 1 from t+N+2G+1.
- Unlock reaction: `i_pll_unlocked` rising → all resets = 1, `o_ready` = 0 and `o_lock_lost` = 1 at most 3 edges later (2 synchronizer edges + 1 state edge).
- `i_pll_unlocked` held at 1: block stays in WAIT_LOCK indefinitely with all resets asserted.

## Structure
- Shared package `reset_seq_pkg` holds:
  - State encodings: WAIT_LOCK = 0, STABLE = 1, REL_ADC = 2, REL_DAC = 3, RUN = 4.
  - Default parameter constants.
- Sub-module `bit_synchronizer`: 2-flop synchronizer with a parameterized reset value. It is reused by the downstream domain reset synchronizers.
- Top level contains the FSM, the shared counter, the output registers and the fault flag. Target size is 150–250 lines.

## Test plan
All scenarios use N = 8, G = 4.
- Clean bring-up: `i_pll_unlocked` 1 → 0 at cycle 10 → `pll_ok` at cycle 12; `o_adc_reset` falls at 21, `o_dac_reset` at 25, `o_core_reset` and `o_ready` at 29; `o_lock_lost` stays 0.
- Glitch during STABLE: unlock pulse 1 cycle long at cycle 5 of STABLE → WAIT_LOCK, counter restarts, `o_lock_lost` stays 0; release times shift by the full N.
- Loss in RUN: `i_pll_unlocked` = 1 → within 3 edges all resets = 1, `o_ready` = 0, `o_lock_lost` = 1. After relock, the full sequence repeats and `o_lock_lost` stays 1.
- Fault clear: pulse `i_clear_fault` → `o_lock_lost` = 0 next edge. Clear coinciding with a new loss event → `o_lock_lost` stays 1.
- Reset mid-sequence: assert `i_reset` in REL_DAC → next edge all outputs at reset values, `o_state` = 0. Deassert with `i_pll_unlocked` = 0 → sequence restarts after the 2-cycle synchronizer delay.
- PLL never locks: `i_pll_unlocked` = 1 for 5000 cycles → resets stay 1, `o_state` = WAIT_LOCK, `o_lock_lost` = 0.
